// File: rtl/shift_pkg.sv
// shift_pkg: shared mode and FSM state encodings for the multi-cycle shifter
package shift_pkg;
    typedef enum logic [2:0] {
        MODE_SLL = 3'b000,
        MODE_SRL = 3'b001,
        MODE_SRA = 3'b010,
        MODE_ROR = 3'b011,
        MODE_ROL = 3'b100
    } mode_e;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;
    function automatic logic mode_legal(input logic [2:0] m);
        return m <= 3'b100;
    endfunction
endpackage

// File: rtl/shift_step_n.sv
// shift_step_n: combinational shift of an N-bit value by 0..STEP bits in one mode
module shift_step_n
    import shift_pkg::*;
#(
    parameter int N    = 32,
    parameter int STEP = 1,
    localparam int KW  = $clog2(STEP) + 1
) (
    input  logic [N-1:0]  val,
    input  logic [KW-1:0] k,
    input  mode_e         mode,
    input  logic          fill,
    output logic [N-1:0]  res
);
    int unsigned ku;
    logic [N-1:0] fill_mask;
    // rotates pull the wrapped bits from the opposite end; a zero distance yields val unchanged
    always_comb begin
        ku = 32'(k);
        fill_mask = fill ? ~({N{1'b1}} >> ku) : '0;
        res = (mode == MODE_SLL) ? val << ku :
              (mode == MODE_SRL) ? val >> ku :
              (mode == MODE_SRA) ? (val >> ku) | fill_mask :
              (mode == MODE_ROR) ? (val >> ku) | (val << (N - ku)) :
              (mode == MODE_ROL) ? (val << ku) | (val >> (N - ku)) : val;
    end
endmodule

// File: rtl/shift_unit_n.sv
// shift_unit_n: handshaked iterative shifter moving up to STEP bits per cycle
module shift_unit_n
    import shift_pkg::*;
#(
    parameter int N    = 32,
    parameter int M    = 5,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [M-1:0] shift_amt,
    input  logic [2:0]   mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic         err
);
    localparam int KW = $clog2(STEP) + 1;
    localparam logic [M:0] STEP_W = (M+1)'(STEP);
    state_e state, state_n;
    logic [N-1:0] work, step_res;
    logic [M:0] cnt, kf, cnt_n;
    mode_e mode_q;
    logic sign, accept, direct;
    shift_step_n #(.N(N), .STEP(STEP)) u_step (
        .val  (work),
        .k    (kf[KW-1:0]),
        .mode (mode_q),
        .fill (mode_q == MODE_SRA && sign),
        .res  (step_res)
    );
    // next-state logic and handshake outputs; a request with nothing to shift goes straight to DONE
    always_comb begin
        in_ready = state == S_IDLE && !rst;
        out_valid = state == S_DONE;
        accept = in_valid && in_ready;
        direct = !mode_legal(mode) || shift_amt == '0;
        kf = (cnt > STEP_W) ? STEP_W : cnt;
        cnt_n = cnt - kf;
        state_n = state;
        unique case (state)
            S_IDLE:  state_n = accept ? (direct ? S_DONE : S_SHIFT) : S_IDLE;
            S_SHIFT: state_n = (cnt_n == '0) ? S_DONE : S_SHIFT;
            S_DONE:  state_n = out_ready ? S_IDLE : S_DONE;
            default: state_n = S_IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk) begin
        state <= rst ? S_IDLE : state_n;
    end
    // datapath: latch the request, iterate the work register, publish the result on the final step
    always_ff @(posedge clk) begin
        if (rst) begin
            work   <= '0;
            cnt    <= '0;
            mode_q <= MODE_SLL;
            sign   <= 1'b0;
            y      <= '0;
            err    <= 1'b0;
        end else if (accept) begin
            work   <= a;
            cnt    <= {1'b0, shift_amt};
            mode_q <= mode_e'(mode);
            sign   <= a[N-1];
            err    <= !mode_legal(mode);
            if (direct) y <= a;
        end else if (state == S_SHIFT) begin
            work <= step_res;
            cnt  <= cnt_n;
            if (cnt_n == '0) y <= step_res;
        end
    end
endmodule

// File: tb/tb_shift_unit_n.sv
// tb_shift_unit_n: directed checks of shift_unit_n across several STEP values
module tb_shift_unit_n;
    logic clk = 1'b0;
    logic rst;
    logic [31:0] a;
    logic [4:0] amt;
    logic [2:0] mode;
    logic iv [5];
    logic ordy [5];
    logic irdy [5];
    logic ov [5];
    logic err [5];
    logic [31:0] y [5];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic int step_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : (d == 2) ? 4 : (d == 3) ? 8 : 32;
    endfunction

    for (genvar g = 0; g < 5; g++) begin : g_dut
        shift_unit_n #(.N(32), .M(5), .STEP(step_of(g))) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (irdy[g]),
            .a         (a),
            .shift_amt (amt),
            .mode      (mode),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .y         (y[g]),
            .err       (err[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gold(input logic [31:0] av, input logic [4:0] s, input logic [2:0] md);
        logic [63:0] t;
        case (md)
            3'd0: return av << s;
            3'd1: return av >> s;
            3'd2: return 32'($signed(av) >>> s);
            3'd3: begin t = {av, av} >> s; return t[31:0]; end
            3'd4: begin t = {av, av} << s; return t[63:32]; end
            default: return av;
        endcase
    endfunction

    task automatic run_op(input int d, input logic [31:0] av, input logic [4:0] s, input logic [2:0] md,
                          input logic [31:0] ey, input logic ee, input int hold);
        int lat, el;
        el = (md > 3'd4 || s == 0) ? 0 : (int'(s) + step_of(d) - 1) / step_of(d);
        chk($sformatf("in_ready_idle[%0d]", d), 32'(irdy[d]), 32'd1);
        a = av; amt = s; mode = md; iv[d] = 1'b1; ordy[d] = 1'b0;
        @(posedge clk); #1;
        iv[d] = 1'b0; a = ~av; amt = ~s; mode = 3'd1;
        lat = 0;
        while (!ov[d] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency[%0d]", d), 32'(lat), 32'(el));
        chk($sformatf("y[%0d]", d), y[d], ey);
        chk($sformatf("err[%0d]", d), 32'(err[d]), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            iv[d] = 1'b1; a = 32'hA5A5_5A5A; amt = 5'd3; mode = 3'd0;
            @(posedge clk); #1;
            chk("hold_ov", 32'(ov[d]), 32'd1);
            chk("hold_y", y[d], ey);
            chk("hold_in_ready", 32'(irdy[d]), 32'd0);
        end
        iv[d] = 1'b0; ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
        chk($sformatf("ov_drop[%0d]", d), 32'(ov[d]), 32'd0);
        chk($sformatf("idle_again[%0d]", d), 32'(irdy[d]), 32'd1);
    endtask

    initial begin
        logic [31:0] rv;
        logic [4:0] rs;
        logic [2:0] rm;
        rst = 1'b1; a = '0; amt = '0; mode = '0;
        for (int i = 0; i < 5; i++) begin iv[i] = 1'b0; ordy[i] = 1'b0; end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("rst_ov", 32'(ov[i]), 32'd0);
            chk("rst_y", y[i], 32'd0);
            chk("rst_err", 32'(err[i]), 32'd0);
            chk("rst_in_ready", 32'(irdy[i]), 32'd0);
        end
        rst = 1'b0; #1;
        chk("in_ready_after_rst", 32'(irdy[0]), 32'd1);
        run_op(0, 32'h8000_0001, 5'd4, 3'd2, 32'hF800_0000, 1'b0, 0);
        run_op(2, 32'h1234_5678, 5'd8, 3'd3, 32'h7812_3456, 1'b0, 0);
        run_op(2, 32'h1234_5678, 5'd31, 3'd4, 32'h091A_2B3C, 1'b0, 0);
        run_op(0, 32'hDEAD_BEEF, 5'd0, 3'd0, 32'hDEAD_BEEF, 1'b0, 0);
        run_op(3, 32'hDEAD_BEEF, 5'd5, 3'd7, 32'hDEAD_BEEF, 1'b1, 0);
        run_op(1, 32'h0000_00FF, 5'd4, 3'd0, 32'h0000_0FF0, 1'b0, 0);
        run_op(3, 32'hF000_0000, 5'd28, 3'd1, 32'h0000_000F, 1'b0, 0);
        run_op(4, 32'h8000_0000, 5'd31, 3'd2, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(4, 32'h8000_0001, 5'd1, 3'd4, 32'h0000_0003, 1'b0, 0);
        run_op(1, 32'h0000_0001, 5'd3, 3'd3, 32'h2000_0000, 1'b0, 0);
        run_op(3, 32'h4000_0000, 5'd9, 3'd2, 32'h0020_0000, 1'b0, 0);
        run_op(2, 32'h0F0F_1234, 5'd6, 3'd1, 32'h003C_3C48, 1'b0, 10);
        a = 32'hCAFE_0123; amt = 5'd20; mode = 3'd1; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_shift_ov", 32'(ov[0]), 32'd0);
        rst = 1'b1; iv[0] = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ov", 32'(ov[0]), 32'd0);
        chk("rst_mid_y", y[0], 32'd0);
        chk("rst_mid_in_ready", 32'(irdy[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; iv[0] = 1'b0; #1;
        chk("post_rst_in_ready", 32'(irdy[0]), 32'd1);
        repeat (25) @(posedge clk);
        #1;
        chk("no_ghost_ov", 32'(ov[0]), 32'd0);
        for (int i = 0; i < 40; i++) begin
            rv = $urandom; rs = 5'($urandom_range(0, 31)); rm = 3'($urandom_range(0, 4));
            run_op(i % 5, rv, rs, rm, gold(rv, rs, rm), 1'b0, int'($urandom_range(0, 3)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
